// File: rtl/alu_arbiter_ctrl.sv
// Round-robin front end that shares one combinational ALU between two requesters.
// Define ALU_FLAGS_REG_EN to build the architectural NZCV flags register.
module alu_arbiter_ctrl #(
    parameter int unsigned MUL_LAT = 2,    // legal 1..15
    parameter bit          RR_INIT = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [32:0] req0_ctrl,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [32:0] req1_ctrl,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_data,
    output logic        rsp_cond_met,
    output logic [3:0]  flags,
    output logic [31:0] alu_in1,
    output logic [31:0] alu_in2,
    output logic [3:0]  alu_opcode,
    output logic [3:0]  alu_cond,
    output logic        alu_s,
    output logic [2:0]  alu_sr_cont,
    output logic [4:0]  alu_sr_bit,
    output logic [15:0] alu_imm,
    input  logic [31:0] alu_out,
    input  logic [3:0]  alu_flags,
    input  logic        alu_cond_met
);

    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_CMP  = 4'b1011;
    localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);

    typedef struct packed {
        logic [3:0]  opcode;
        logic [3:0]  cond;
        logic        s;
        logic [2:0]  sr_cont;
        logic [4:0]  sr_bit;
        logic [15:0] imm;
    } ctrl_t;

    typedef struct packed {
        logic        id;
        ctrl_t       ctrl;
        logic [31:0] a;
        logic [31:0] b;
    } op_t;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t     state_q, state_d;
    op_t        op_q, win_op;
    logic       prio_q;
    logic [3:0] cnt_q;
    logic [1:0] grant;
    logic       accept, capture;

    // prio_q names the slot that wins a tie; it always points away from the last winner.
    always_comb begin
        grant = {req1_valid, req0_valid};
        if (req0_valid && req1_valid)
            grant = prio_q ? 2'b10 : 2'b01;
    end

    always_comb begin
        if (grant[1])
            win_op = {1'b1, ctrl_t'(req1_ctrl), req1_a, req1_b};
        else
            win_op = {1'b0, ctrl_t'(req0_ctrl), req0_a, req0_b};
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (|grant) begin
                    accept  = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q == 4'd0) begin
                    capture = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Readies are gated by rst so every output reads 0 while reset is held.
    always_comb begin
        req0_ready = (state_q == IDLE) && grant[0] && !rst;
        req1_ready = (state_q == IDLE) && grant[1] && !rst;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            op_q         <= '0;
            prio_q       <= RR_INIT;
            cnt_q        <= 4'd0;
            rsp_valid    <= 1'b0;
            rsp_id       <= 1'b0;
            rsp_data     <= 32'd0;
            rsp_cond_met <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q   <= win_op;
                prio_q <= ~win_op.id;
                cnt_q  <= (win_op.ctrl.opcode == OP_MUL) ? MUL_CNT : 4'd0;
            end else if (state_q == EXEC && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (capture) begin
                rsp_valid    <= 1'b1;
                rsp_id       <= op_q.id;
                rsp_data     <= alu_out;
                rsp_cond_met <= alu_cond_met;
            end else if (state_q == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

    assign alu_in1     = op_q.a;
    assign alu_in2     = op_q.b;
    assign alu_opcode  = op_q.ctrl.opcode;
    assign alu_cond    = op_q.ctrl.cond;
    assign alu_s       = op_q.ctrl.s;
    assign alu_sr_cont = op_q.ctrl.sr_cont;
    assign alu_sr_bit  = op_q.ctrl.sr_bit;
    assign alu_imm     = op_q.ctrl.imm;

`ifdef ALU_FLAGS_REG_EN
    logic [3:0] flags_q;

    // Only compares and flag-setting ops whose condition passed commit NZCV.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            flags_q <= 4'b0000;
        else if (capture && alu_cond_met && (op_q.ctrl.opcode == OP_CMP || op_q.ctrl.s))
            flags_q <= alu_flags;
    end

    assign flags = flags_q;
`else
    logic unused_alu_flags;

    assign unused_alu_flags = ^alu_flags;
    assign flags            = 4'b0000;
`endif

endmodule
